// File: rtl/mem_axi_window_pkg.sv
// Shared constants, state enums and the address-channel bundle
// for the Top-to-PS AXI address window bridge.
package mem_axi_window_pkg;

   localparam int ID_W   = 6;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [3:0] SRC_NIBBLE = 4'h8;
   localparam logic [3:0] DST_NIBBLE = 4'h1;
   localparam logic [3:0] OUT_MAX    = 4'd15;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_SINK,
      W_BRESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_ERR
   } r_state_t;

   typedef struct packed {
      logic [31:0]     addr;
      logic [ID_W-1:0] id;
      logic [7:0]      len;
      logic [2:0]      size;
      logic [1:0]      burst;
      logic            lock;
      logic [3:0]      cache;
      logic [2:0]      prot;
      logic [3:0]      qos;
   } ax_t;

   function automatic logic [31:0] remap(input logic [31:0] a);
      return {DST_NIBBLE, a[27:0]};
   endfunction

endpackage

// File: rtl/mem_axi_window_slice.sv
// Two-entry skid register slice; s_ready is registered so there is
// no combinational path from m_ready back to s_ready.
module axi_reg_slice #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic         empty
);

   logic [W-1:0] out_q;
   logic [W-1:0] skid_q;
   logic         out_v;
   logic         skid_v;
   logic         run_q;
   logic         s_fire;
   logic         adv;

   assign s_ready = run_q & ~skid_v;
   assign s_fire  = s_valid & s_ready;
   assign adv     = ~out_v | m_ready;
   assign m_valid = out_v;
   assign m_data  = out_q;
   assign empty   = ~out_v & ~skid_v;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         run_q  <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         run_q <= 1'b1;
         if (adv) begin
            if (skid_v) begin
               out_v  <= 1'b1;
               out_q  <= skid_q;
               skid_v <= 1'b0;
            end else begin
               out_v <= s_fire;
               out_q <= s_data;
            end
         end else if (s_fire) begin
            skid_v <= 1'b1;
            skid_q <= s_data;
         end
      end
   end

endmodule

// File: rtl/mem_axi_window.sv
// Address window bridge: remaps 0x8xxx_xxxx to 0x1xxx_xxxx and
// answers out-of-window requests locally with DECERR.
module mem_axi_window
   import mem_axi_window_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              s_aw_valid,
   output logic              s_aw_ready,
   input  logic [31:0]       s_aw_addr,
   input  logic [ID_W-1:0]   s_aw_id,
   input  logic [7:0]        s_aw_len,
   input  logic [2:0]        s_aw_size,
   input  logic [1:0]        s_aw_burst,
   input  logic              s_aw_lock,
   input  logic [3:0]        s_aw_cache,
   input  logic [2:0]        s_aw_prot,
   input  logic [3:0]        s_aw_qos,
   input  logic              s_w_valid,
   output logic              s_w_ready,
   input  logic [DATA_W-1:0] s_w_data,
   input  logic [STRB_W-1:0] s_w_strb,
   input  logic              s_w_last,
   output logic              s_b_valid,
   input  logic              s_b_ready,
   output logic [ID_W-1:0]   s_b_id,
   output logic [1:0]        s_b_resp,
   input  logic              s_ar_valid,
   output logic              s_ar_ready,
   input  logic [31:0]       s_ar_addr,
   input  logic [ID_W-1:0]   s_ar_id,
   input  logic [7:0]        s_ar_len,
   input  logic [2:0]        s_ar_size,
   input  logic [1:0]        s_ar_burst,
   input  logic              s_ar_lock,
   input  logic [3:0]        s_ar_cache,
   input  logic [2:0]        s_ar_prot,
   input  logic [3:0]        s_ar_qos,
   output logic              s_r_valid,
   input  logic              s_r_ready,
   output logic [ID_W-1:0]   s_r_id,
   output logic [DATA_W-1:0] s_r_data,
   output logic [1:0]        s_r_resp,
   output logic              s_r_last,
   output logic              m_aw_valid,
   input  logic              m_aw_ready,
   output logic [31:0]       m_aw_addr,
   output logic [ID_W-1:0]   m_aw_id,
   output logic [7:0]        m_aw_len,
   output logic [2:0]        m_aw_size,
   output logic [1:0]        m_aw_burst,
   output logic              m_aw_lock,
   output logic [3:0]        m_aw_cache,
   output logic [2:0]        m_aw_prot,
   output logic [3:0]        m_aw_qos,
   output logic              m_w_valid,
   input  logic              m_w_ready,
   output logic [DATA_W-1:0] m_w_data,
   output logic [STRB_W-1:0] m_w_strb,
   output logic              m_w_last,
   input  logic              m_b_valid,
   output logic              m_b_ready,
   input  logic [ID_W-1:0]   m_b_id,
   input  logic [1:0]        m_b_resp,
   output logic              m_ar_valid,
   input  logic              m_ar_ready,
   output logic [31:0]       m_ar_addr,
   output logic [ID_W-1:0]   m_ar_id,
   output logic [7:0]        m_ar_len,
   output logic [2:0]        m_ar_size,
   output logic [1:0]        m_ar_burst,
   output logic              m_ar_lock,
   output logic [3:0]        m_ar_cache,
   output logic [2:0]        m_ar_prot,
   output logic [3:0]        m_ar_qos,
   input  logic              m_r_valid,
   output logic              m_r_ready,
   input  logic [ID_W-1:0]   m_r_id,
   input  logic [DATA_W-1:0] m_r_data,
   input  logic [1:0]        m_r_resp,
   input  logic              m_r_last,
   output logic [15:0]       err_count
);

   ax_t aw_in, aw_out, ar_in, ar_out;

   logic aw_legal, ar_legal;
   logic aw_sl_rdy, aw_sl_empty;
   logic ar_sl_rdy, ar_sl_empty;
   logic aw_fire, aw_good, aw_bad;
   logic ar_fire, ar_good, ar_bad;
   logic w_fire, w_done;
   logic b_fire, rl_fire;
   logic r_last;

   logic [3:0] wr_out, rd_out;
   logic [3:0] fifo_mem;
   logic [1:0] fifo_wp, fifo_rp;
   logic [2:0] fifo_cnt;
   logic       fifo_full, fifo_empty, fifo_head;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [ID_W-1:0] b_id_q, r_id_q;
   logic [7:0]      r_len_q, r_beat_q;
   logic [16:0]     err_sum;

   assign aw_legal = s_aw_addr[31:28] == SRC_NIBBLE;
   assign ar_legal = s_ar_addr[31:28] == SRC_NIBBLE;

   assign aw_in = {remap(s_aw_addr), s_aw_id, s_aw_len,
                   s_aw_size, s_aw_burst, s_aw_lock,
                   s_aw_cache, s_aw_prot, s_aw_qos};
   assign ar_in = {remap(s_ar_addr), s_ar_id, s_ar_len,
                   s_ar_size, s_ar_burst, s_ar_lock,
                   s_ar_cache, s_ar_prot, s_ar_qos};

   assign fifo_full  = fifo_cnt == 3'd4;
   assign fifo_empty = fifo_cnt == 3'd0;
   assign fifo_head  = fifo_mem[fifo_rp];

   // Rejects wait for a fully quiet direction so responses stay in order.
   assign s_aw_ready = aw_sl_rdy && (wr_out != OUT_MAX) && !fifo_full &&
                       (aw_legal || (wr_out == 4'd0 && aw_sl_empty &&
                                     w_state == W_IDLE));
   assign s_ar_ready = ar_sl_rdy && (rd_out != OUT_MAX) &&
                       (ar_legal || (rd_out == 4'd0 && ar_sl_empty &&
                                     r_state == R_IDLE));

   assign aw_fire = s_aw_valid && s_aw_ready;
   assign aw_good = aw_fire && aw_legal;
   assign aw_bad  = aw_fire && !aw_legal;
   assign ar_fire = s_ar_valid && s_ar_ready;
   assign ar_good = ar_fire && ar_legal;
   assign ar_bad  = ar_fire && !ar_legal;

   axi_reg_slice #(.W($bits(ax_t))) u_aw_slice (
      .clock   (clock),
      .reset_n (reset_n),
      .s_valid (aw_good),
      .s_ready (aw_sl_rdy),
      .s_data  (aw_in),
      .m_valid (m_aw_valid),
      .m_ready (m_aw_ready),
      .m_data  (aw_out),
      .empty   (aw_sl_empty)
   );

   axi_reg_slice #(.W($bits(ax_t))) u_ar_slice (
      .clock   (clock),
      .reset_n (reset_n),
      .s_valid (ar_good),
      .s_ready (ar_sl_rdy),
      .s_data  (ar_in),
      .m_valid (m_ar_valid),
      .m_ready (m_ar_ready),
      .m_data  (ar_out),
      .empty   (ar_sl_empty)
   );

   assign m_aw_addr  = aw_out.addr;
   assign m_aw_id    = aw_out.id;
   assign m_aw_len   = aw_out.len;
   assign m_aw_size  = aw_out.size;
   assign m_aw_burst = aw_out.burst;
   assign m_aw_lock  = aw_out.lock;
   assign m_aw_cache = aw_out.cache;
   assign m_aw_prot  = aw_out.prot;
   assign m_aw_qos   = aw_out.qos;

   assign m_ar_addr  = ar_out.addr;
   assign m_ar_id    = ar_out.id;
   assign m_ar_len   = ar_out.len;
   assign m_ar_size  = ar_out.size;
   assign m_ar_burst = ar_out.burst;
   assign m_ar_lock  = ar_out.lock;
   assign m_ar_cache = ar_out.cache;
   assign m_ar_prot  = ar_out.prot;
   assign m_ar_qos   = ar_out.qos;

   assign m_w_data = s_w_data;
   assign m_w_strb = s_w_strb;
   assign m_w_last = s_w_last;

   always_comb begin
      m_w_valid = 1'b0;
      s_w_ready = 1'b0;
      if (!fifo_empty) begin
         if (fifo_head) begin
            m_w_valid = s_w_valid;
            s_w_ready = m_w_ready;
         end else begin
            s_w_ready = 1'b1;
         end
      end
   end

   assign w_fire  = s_w_valid && s_w_ready;
   assign w_done  = w_fire && s_w_last;
   assign b_fire  = m_b_valid && m_b_ready;
   assign rl_fire = m_r_valid && m_r_ready && m_r_last;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fifo_mem <= '0;
         fifo_wp  <= '0;
         fifo_rp  <= '0;
         fifo_cnt <= '0;
         wr_out   <= '0;
         rd_out   <= '0;
      end else begin
         if (aw_fire) begin
            fifo_mem[fifo_wp] <= aw_legal;
            fifo_wp <= fifo_wp + 2'd1;
         end
         if (w_done) fifo_rp <= fifo_rp + 2'd1;
         fifo_cnt <= fifo_cnt + {2'b0, aw_fire} - {2'b0, w_done};
         wr_out <= wr_out + {3'b0, aw_good} - {3'b0, b_fire};
         rd_out <= rd_out + {3'b0, ar_good} - {3'b0, rl_fire};
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_bad) w_next = W_SINK;
         W_SINK:  if (w_done && !fifo_head) w_next = W_BRESP;
         W_BRESP: if (s_b_ready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      s_b_valid = m_b_valid && reset_n;
      s_b_id    = m_b_id;
      s_b_resp  = m_b_resp;
      m_b_ready = s_b_ready;
      if (w_state == W_BRESP) begin
         s_b_valid = 1'b1;
         s_b_id    = b_id_q;
         s_b_resp  = RESP_DECERR;
         m_b_ready = 1'b0;
      end
   end

   assign r_last = r_beat_q == r_len_q;

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_bad) r_next = R_ERR;
         R_ERR:   if (s_r_ready && r_last) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      s_r_valid = m_r_valid && reset_n;
      s_r_id    = m_r_id;
      s_r_data  = m_r_data;
      s_r_resp  = m_r_resp;
      s_r_last  = m_r_last;
      m_r_ready = s_r_ready;
      if (r_state == R_ERR) begin
         s_r_valid = 1'b1;
         s_r_id    = r_id_q;
         s_r_data  = '0;
         s_r_resp  = RESP_DECERR;
         s_r_last  = r_last;
         m_r_ready = 1'b0;
      end
   end

   assign err_sum = {1'b0, err_count} + {16'b0, aw_bad} + {16'b0, ar_bad};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         b_id_q    <= '0;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_beat_q  <= '0;
         err_count <= '0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         if (aw_bad) b_id_q <= s_aw_id;
         if (ar_bad) begin
            r_id_q   <= s_ar_id;
            r_len_q  <= s_ar_len;
            r_beat_q <= '0;
         end else if (r_state == R_ERR && s_r_ready) begin
            r_beat_q <= r_beat_q + 8'd1;
         end
         err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

endmodule
